game_sequencer: RTL and testbench



---
 rtl/game_sequencer_if.sv | 20 ++
 rtl/game_sequencer.sv | 127 ++++++++++++
 tb/tb_game_sequencer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/game_sequencer_if.sv
// Snake game sequencer bus: button/event inputs and mode/score/step outputs.
interface game_sequencer_if;
  logic       middle;
  logic       eat;
  logic       collide;
  logic [1:0] mode;
  logic [3:0] score;
  logic       step;
  logic       win;

  modport master (
    output middle, eat, collide,
    input  mode, score, step, win
  );

  modport slave (
    input  middle, eat, collide,
    output mode, score, step, win
  );
endinterface

// File: rtl/game_sequencer.sv
// Snake game mode/score/step sequencer.
// Define GAME_SEQ_SPEEDUP_EN to shorten the step period as score grows.
module game_sequencer #(
  parameter int STEP_DIV  = 6250000,
  parameter int CNT_W     = 24,
  parameter int MAX_SCORE = 15,
  parameter int OVER_HOLD = 12500000,
  parameter int STEP_DEC  = 250000,
  parameter int STEP_MIN  = 2500000
) (
  input logic             clk,
  input logic             rst_n,
  game_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PLAY  = 2'b01,
    S_PAUSE = 2'b10,
    S_OVER  = 2'b11
  } state_t;

`ifdef GAME_SEQ_SPEEDUP_EN
  localparam bit SPEEDUP = 1'b1;
`else
  localparam bit SPEEDUP = 1'b0;
`endif

  localparam int DEC    = SPEEDUP ? STEP_DEC : 0;
  localparam int FLOOR  = SPEEDUP ? STEP_MIN : STEP_DIV;
  localparam int HOLD_W = $clog2(OVER_HOLD + 1);

  state_t             r_state;
  state_t             w_next;
  logic               r_mid_q;
  logic [CNT_W-1:0]   r_cnt;
  logic [HOLD_W-1:0]  r_hold;
  logic [3:0]         r_score;
  logic               r_step;
  logic               r_win;

  logic               w_rise;
  logic               w_hold_done;
  logic [3:0]         w_score_inc;
  logic               w_max;
  logic               w_stay_play;
  logic               w_wrap;
  logic [31:0]        w_dec;
  logic [31:0]        w_per;
  logic [CNT_W-1:0]   w_lim;

  assign w_rise      = bus.middle & ~r_mid_q;
  assign w_hold_done = r_hold >= HOLD_W'(OVER_HOLD);
  assign w_score_inc = r_score + 4'd1;
  assign w_max       = w_score_inc == 4'(MAX_SCORE);

  // Period is recomputed every cycle so a new score shortens the current interval
  always_comb begin
    w_dec = 32'(r_score) * 32'(DEC);
    if (w_dec + 32'(FLOOR) >= 32'(STEP_DIV))
      w_per = 32'(FLOOR);
    else
      w_per = 32'(STEP_DIV) - w_dec;
    w_lim = CNT_W'(w_per - 32'd1);
  end

  assign w_wrap      = r_cnt >= w_lim;
  assign w_stay_play = (r_state == S_PLAY) && (w_next == S_PLAY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_rise) w_next = S_PLAY;
      S_PLAY: begin
        if (bus.collide)          w_next = S_OVER;
        else if (bus.eat && w_max) w_next = S_OVER;
        else if (w_rise)          w_next = S_PAUSE;
      end
      S_PAUSE: if (w_rise) w_next = S_PLAY;
      S_OVER:  if (w_rise && w_hold_done) w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mid_q <= 1'b0;
      r_cnt   <= '0;
      r_hold  <= '0;
      r_score <= '0;
      r_step  <= 1'b0;
      r_win   <= 1'b0;
    end else begin
      r_mid_q <= bus.middle;
      r_step  <= w_stay_play && w_wrap;
      if (r_state == S_IDLE && w_rise) begin
        r_score <= '0;
        r_win   <= 1'b0;
        r_cnt   <= '0;
      end
      // Counter only advances on edges that keep the game in PLAY
      if (w_stay_play)
        r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
      if (r_state == S_PLAY && !bus.collide && bus.eat &&
          r_score != 4'(MAX_SCORE))
        r_score <= w_score_inc;
      if (r_state == S_PLAY && w_next == S_OVER) begin
        r_win  <= ~bus.collide;
        r_hold <= '0;
      end else if (r_state == S_OVER && !w_hold_done) begin
        r_hold <= r_hold + HOLD_W'(1);
      end
    end
  end

  always_comb begin
    bus.mode  = r_state;
    bus.score = r_score;
    bus.step  = r_step;
    bus.win   = r_win;
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer against a behavioural model.
module tb_game_sequencer;
  localparam int DIV  = 8;
  localparam int HOLD = 4;
  localparam int MAXS = 3;
  localparam int DEC  = 2;
  localparam int MINP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  game_sequencer_if bus();

  game_sequencer #(
    .STEP_DIV (DIV),
    .CNT_W    (4),
    .MAX_SCORE(MAXS),
    .OVER_HOLD(HOLD),
    .STEP_DEC (DEC),
    .STEP_MIN (MINP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  int m_mode, m_score, m_win, m_step, m_phase, m_age;
  bit m_prev;

  task automatic chk(input string name, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  function automatic int period(input int s);
`ifdef GAME_SEQ_SPEEDUP_EN
    int p;
    p = DIV - s * DEC;
    return (p < MINP) ? MINP : p;
`else
    return DIV + 0 * s;
`endif
  endfunction

  task automatic model_reset();
    m_mode = 0; m_score = 0; m_win = 0; m_step = 0;
    m_phase = 0; m_age = 0; m_prev = 1'b0;
  endtask

  task automatic model_edge(input bit mid, input bit e, input bit c);
    bit rise;
    int per;
    rise   = mid && !m_prev;
    m_prev = mid;
    per    = period(m_score);
    m_step = 0;
    case (m_mode)
      0: if (rise) begin
        m_mode = 1; m_score = 0; m_win = 0; m_phase = 0;
      end
      1: if (c) begin
        m_mode = 3; m_win = 0; m_age = 0;
      end else begin
        if (e) m_score++;
        if (e && m_score == MAXS) begin
          m_mode = 3; m_win = 1; m_age = 0;
        end else if (rise) begin
          m_mode = 2;
        end else begin
          m_phase++;
          if (m_phase >= per) begin
            m_phase = 0; m_step = 1;
          end
        end
      end
      2: if (rise) m_mode = 1;
      default: if (rise && m_age >= HOLD) m_mode = 0; else m_age++;
    endcase
  endtask

  task automatic check_model();
    chk("mode",  int'(bus.mode),  m_mode);
    chk("score", int'(bus.score), m_score);
    chk("step",  int'(bus.step),  m_step);
    chk("win",   int'(bus.win),   m_win);
  endtask

  task automatic tick(input bit mid, input bit e, input bit c);
    bus.middle  = mid;
    bus.eat     = e;
    bus.collide = c;
    @(posedge clk);
    model_edge(mid, e, c);
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    bus.middle = 1'b0; bus.eat = 1'b0; bus.collide = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int s1, s2, nst, nchg, wt;
    logic [1:0] pm;
    int sidx[4];
    int ns;
    bit mid;

    bus.middle = 1'b0; bus.eat = 1'b0; bus.collide = 1'b0;
    model_reset();
    #12;
    chk("rst_mode",  int'(bus.mode),  0);
    chk("rst_score", int'(bus.score), 0);
    chk("rst_step",  int'(bus.step),  0);
    chk("rst_win",   int'(bus.win),   0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: held button enters PLAY once; steps at 8 and 16
    s1 = -1; s2 = -1; nst = 0; nchg = 0; pm = bus.mode;
    for (int k = 0; k < 20; k++) begin
      tick(1'b1, 1'b0, 1'b0);
      if (bus.mode != pm) nchg++;
      pm = bus.mode;
      if (bus.step) begin
        nst++;
        if (s1 < 0) s1 = k; else if (s2 < 0) s2 = k;
      end
    end
    chk("t1_mode_changes", nchg, 1);
    chk("t1_mode", int'(bus.mode), 1);
    chk("t1_step_a", s1, 8);
    chk("t1_step_b", s2, 16);
    chk("t1_nsteps", nst, 2);

    // 2: pause at counter 5, resume, step after 3 cycles
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    chk("t2_paused", int'(bus.mode), 2);
    nst = 0;
    for (int k = 0; k < 10; k++) begin
      tick(1'b0, 1'b0, 1'b0);
      if (bus.step) nst++;
    end
    chk("t2_pause_steps", nst, 0);
    tick(1'b1, 1'b0, 1'b0);
    chk("t2_resumed", int'(bus.mode), 1);
    wt = -1;
    for (int k = 1; k <= 20 && wt < 0; k++) begin
      tick(1'b0, 1'b0, 1'b0);
      if (bus.step) wt = k;
    end
    chk("t2_resume_step", wt, 3);

    // 3: three eats win the game
    for (int i = 1; i <= 3; i++) begin
      tick(1'b0, 1'b1, 1'b0);
      chk("t3_score", int'(bus.score), i);
      if (i < 3) tick(1'b0, 1'b0, 1'b0);
    end
    chk("t3_mode", int'(bus.mode), 3);
    chk("t3_win", int'(bus.win), 1);

    // 5: early rise ignored, late rise goes IDLE, next rise restarts
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    chk("t5_early_ignored", int'(bus.mode), 3);
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    chk("t5_idle", int'(bus.mode), 0);
    chk("t5_score_kept", int'(bus.score), 3);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    chk("t5_play", int'(bus.mode), 1);
    chk("t5_score_clr", int'(bus.score), 0);

    // 4: eat with collide loses without scoring
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b1);
    chk("t4_mode", int'(bus.mode), 3);
    chk("t4_score", int'(bus.score), 1);
    chk("t4_win", int'(bus.win), 0);

    // 6: async reset mid-PLAY
    for (int k = 0; k < 6; k++) tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    #2;
    bus.middle = 1'b0; bus.eat = 1'b0; bus.collide = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_mode", int'(bus.mode), 0);
    chk("t6_score", int'(bus.score), 0);
    chk("t6_step", int'(bus.step), 0);
    chk("t6_win", int'(bus.win), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

`ifdef GAME_SEQ_SPEEDUP_EN
    tick(1'b1, 1'b0, 1'b0);
    ns = 0;
    for (int k = 1; k <= 40 && ns < 4; k++) begin
      tick(1'b0, (ns == 1 || ns == 2) && bus.step, 1'b0);
      if (bus.step) begin
        sidx[ns] = k;
        ns++;
      end
    end
    chk("sp_n", ns, 4);
    chk("sp_gap0", sidx[0], 8);
    chk("sp_gap1", sidx[1] - sidx[0], 6);
    chk("sp_gap2", sidx[2] - sidx[1], 4);
    chk("sp_gap3", sidx[3] - sidx[2], 4);
    do_reset();
`else
    ns = 0;
    sidx[0] = 0;
`endif

    // random play against the model
    mid = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 5) == 0) mid = ~mid;
      tick(mid, $urandom_range(0, 7) == 0, $urandom_range(0, 29) == 0);
      if (k % 997 == 996) do_reset();
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
